// File: rtl/zf_stage_scheduler.sv
// Frame scheduler for the three-stage ZF back-substitution chain: per-link enable/hold/release FSMs,
// stale-ready masking and frame counters. Optional per-stage watchdog under ZF_SCHED_TIMEOUT_EN.
module zf_stage_scheduler #(
  parameter int unsigned HOLD_CYCLES    = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_accept,
  output logic [2:0]       s_enable,
  output logic [2:0]       s_accept_in,
  input  logic [2:0]       s_accept_out,
  input  logic [2:0]       s_ready_out,
  output logic             out_ready,
  input  logic             out_accept,
  output logic             busy,
  output logic [CNT_W-1:0] frames_in,
  output logic [CNT_W-1:0] frames_out,
  output logic             timeout_err
);

  localparam int unsigned HW = 4;

  typedef enum logic [2:0] {
    L_WAIT    = 3'd0,
    L_LAUNCH  = 3'd1,
    L_HOLD    = 3'd2,
    L_RELEASE = 3'd3,
    L_MASK    = 3'd4
  } link_state_t;

  logic [2:0] mask;
  logic [2:0] rdy;
  logic [2:0] src_rdy;
  logic [2:0] link_en;
  logic [2:0] link_rel;
  logic [2:0] link_active;
  logic       handshake;

  // Mask hides the one stale result-valid cycle a stage shows after release.
  assign rdy         = s_ready_out & ~mask;
  assign src_rdy     = {rdy[1], rdy[0], in_valid};
  assign out_ready   = rdy[2];
  assign handshake   = out_ready & out_accept;
  assign s_enable    = link_en;
  assign in_accept   = link_rel[0];
  assign s_accept_in = {handshake, link_rel[2:1]};
  assign busy        = ~&s_accept_out | |link_active;

  // Link k feeds stage k from its source (input for k=0, stage k-1 otherwise).
  for (genvar k = 0; k < 3; k++) begin : g_link
    link_state_t     state;
    logic [HW-1:0]   hold_cnt;
    logic            en_q;
    logic            rel_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state    <= L_WAIT;
        hold_cnt <= '0;
        en_q     <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        en_q  <= 1'b0;
        rel_q <= 1'b0;
        case (state)
          L_WAIT: begin
            if (src_rdy[k] && s_accept_out[k]) begin
              state <= L_LAUNCH;
              en_q  <= 1'b1;
            end
          end
          L_LAUNCH: begin
            state    <= L_HOLD;
            hold_cnt <= HW'(HOLD_CYCLES);
          end
          L_HOLD: begin
            if (hold_cnt == HW'(1)) begin
              state <= L_RELEASE;
              rel_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          L_RELEASE: state <= L_MASK;
          L_MASK:    state <= L_WAIT;
          default:   state <= L_WAIT;
        endcase
      end
    end

    assign link_en[k]     = en_q;
    assign link_rel[k]    = rel_q;
    assign link_active[k] = (state != L_WAIT);
  end

  // Mask bits and frame counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask       <= '0;
      frames_in  <= '0;
      frames_out <= '0;
    end else begin
      mask <= {handshake, link_rel[2], link_rel[1]};
      if (link_rel[0]) frames_in  <= frames_in + CNT_W'(1);
      if (handshake)   frames_out <= frames_out + CNT_W'(1);
    end
  end

`ifdef ZF_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt [3];
  logic [2:0]    wd_active;

  // Watchdog: counts from each stage enable until its result becomes visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_active   <= '0;
      timeout_err <= 1'b0;
      for (int k = 0; k < 3; k++) wd_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (s_enable[k]) begin
          wd_active[k] <= 1'b1;
          wd_cnt[k]    <= '0;
        end else if (wd_active[k]) begin
          if (rdy[k]) begin
            wd_active[k] <= 1'b0;
          end else if (wd_cnt[k] == TW'(TIMEOUT_CYCLES)) begin
            timeout_err <= 1'b1;
          end else begin
            wd_cnt[k] <= wd_cnt[k] + TW'(1);
          end
        end
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
